// File: rtl/seq_divider.sv
// seq_divider: iterative restoring unsigned divider, 2W/W -> 2W quotient + W remainder, one bit per clock.
// Optional SEQ_DIVIDER_EARLY_OUT_EN: single-cycle results for dividend < divisor and divisor == 1.
module seq_divider #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] quotient,
  output logic [W-1:0]   remainder,
  output logic           div_zero,
  output logic           busy
);
  localparam int CW = $clog2(2*W+1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [2*W-1:0] sh;
  logic [W-1:0] dvs, rem_r, r_nx, fast_r;
  logic [W:0] r_sh;
  logic [CW-1:0] cnt;
  logic [2*W-1:0] fast_q;
  logic ge, last, accept, fast, fast_z;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign accept    = in_valid & in_ready;
  // sh shifts the dividend out of its MSB and collects quotient bits in its LSB
  always_comb begin
    r_sh = {rem_r, sh[2*W-1]};
    ge   = r_sh >= {1'b0, dvs};
    r_nx = ge ? W'(r_sh - {1'b0, dvs}) : r_sh[W-1:0];
    last = cnt == CW'(2*W-1);
  end
  always_comb begin
    fast_z = divisor == '0;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    fast   = fast_z || (dividend < {{W{1'b0}}, divisor}) || (divisor == W'(1));
    fast_q = fast_z ? '1 : (divisor == W'(1) ? dividend : '0);
    fast_r = divisor == W'(1) ? '0 : dividend[W-1:0];
`else
    fast   = fast_z;
    fast_q = '1;
    fast_r = dividend[W-1:0];
`endif
  end
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (accept ? (fast ? DONE : CALC) : IDLE)
             : state == CALC ? (last ? DONE : CALC)
             : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh        <= '0;
      dvs       <= '0;
      rem_r     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (accept) begin
      sh    <= dividend;
      dvs   <= divisor;
      rem_r <= '0;
      cnt   <= '0;
      if (fast) begin
        quotient  <= fast_q;
        remainder <= fast_r;
        div_zero  <= fast_z;
      end
    end else if (state == CALC) begin
      sh    <= {sh[2*W-2:0], ge};
      rem_r <= r_nx;
      cnt   <= cnt + CW'(1);
      if (last) begin
        quotient  <= {sh[2*W-2:0], ge};
        remainder <= r_nx;
        div_zero  <= 1'b0;
      end
    end
  end
endmodule
